cc3_viterbi_decoder: RTL and testbench
======================================

# cc3_viterbi_decoder

Hard-decision, 4-state Viterbi decoder for the rate-1/2 `Convolutional_Code_3` channel code. It consumes the `out1`/`out2` symbol pair stream after it has passed through the noise-injection model and recovers the original `in` bit stream. Isolated single-symbol errors, as produced by the noise injector, are corrected. It sits at the receive end of the cc3 link and gives the equivalence/synthesis flow a decoder to close the encode–noise–decode loop.

## Interface
- `TB_DEPTH`, 15 — survivor (register-exchange) depth in bits; legal range 4..32.
- `METRIC_W`, 6 — path-metric width; must be at least 4.
- `clock` in 1 — single clock, rising edge.
- `reset` in 1 — synchronous, active-high.
- `sym_valid` in 1 — `sym1`/`sym2` carry a valid symbol pair this cycle.
- `sym1` in 1 — received code bit for generator 1 (encoder `out1`).
- `sym2` in 1 — received code bit for generator 2 (encoder `out2`).
- `dec_valid` out 1 — one-cycle pulse: `dec_bit` is valid.
- `dec_bit` out 1 — decoded information bit.
- `err_cnt` out 16 — corrected-bit counter; present only with `CC3_ERR_COUNT_EN`.

## Operation
- Encoder model: `sym1 = u^r2`, `sym2 = u^r1^r2`, where `u = r0` is the information bit delayed by one encoder cycle.
- Trellis state `s = {a,b} = {r1,r2}`, with `a` as the MSB. A branch with hypothesised bit `u` has expected pair `e1 = u^b`, `e2 = u^a^b` and next state `{u,a}`.
- Branch metric: `(sym1^e1) + (sym2^e2)`, giving a value of 0..2.
- ACS: the predecessors of state `{u,a}` are `{a,0}` and `{a,1}`.
  - New metric = min over the predecessors of (predecessor metric + branch metric).
  - On a tie, select the predecessor with `b=0`.
- Survivor update: `surv_new = {surv_pred[TB_DEPTH-2:0], u}`.
- Normalisation: if all four new metrics have their MSB set, clear the MSB of all four in the same update. Metrics never wrap.
- Decision:
  - Best state = minimum new metric, with ties going to the lowest index.
  - `dec_bit` = `surv_best[TB_DEPTH-1]`.
- Fill counter: counts accepted symbols and saturates at `TB_DEPTH`. `dec_valid` is asserted only once the count reaches `TB_DEPTH`, i.e. from the `TB_DEPTH`-th accepted symbol on.
- When `sym_valid` is 0, metrics, survivors, the fill counter and outputs hold. The exception is `dec_valid`, which drops to 0.
- Reset values:
  - All metrics 0, because the encoder start state is unknown.
  - Survivors 0, fill counter 0.
  - `dec_valid` 0, `dec_bit` 0, `err_cnt` 0.

## Timing
- A symbol pair accepted at edge E updates the metrics and survivors at E.
- `dec_bit`/`dec_valid` are registered at edge E+1, from the metrics and survivors as updated at E.
- Decoded bit `k` is the hypothesis for accepted symbol `k`. It appears with the acceptance of symbol `k+TB_DEPTH-1`, one cycle after that edge.
- Back-to-back `sym_valid` gives one decoded bit per cycle. There is no backpressure.
- `reset` has priority over `sym_valid` in the same cycle.
- A mid-stream reset discards all history. The first `dec_valid` after reset requires `TB_DEPTH` new symbols.

## Configuration
- Macro: `CC3_ERR_COUNT_EN`.
- Defined:
  - `err_cnt` exists.
  - On every accepted symbol, `err_cnt` adds the branch metric of the survivor branch into the best state.
  - It saturates at 16'hFFFF and is cleared by `reset`.
  - It updates in the same cycle as `dec_bit`.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset: assert `reset` for 2 cycles with `sym_valid=1`. All outputs must read 0 and there must be no `dec_valid` for 14 further accepted symbols (`TB_DEPTH=15`).
- Impulse, noise-free:
  - Stimulus: pairs (1,1),(0,1),(1,1), then (0,0)×20.
  - Required response: the first `dec_valid` comes one cycle after the 15th accepted symbol, with `dec_bit` sequence 1,0,0,…
  - With `CC3_ERR_COUNT_EN`: `err_cnt` stays 0.
- Single error:
  - Stimulus: the same stream with `sym2` of pair 2 flipped to 0.
  - Required response: identical decoded bits.
  - With `CC3_ERR_COUNT_EN`: `err_cnt` ends at 1.
- Gaps:
  - Stimulus: a random 64-bit message, encoded, with `sym_valid` deasserted every third cycle.
  - Required response: the decoded sequence equals the message. There is exactly one `dec_valid` per accepted symbol after fill, and none during gaps.
- Normalisation:
  - Stimulus: 500 symbols of alternating noise-free and single-flipped pairs, with `METRIC_W=4`.
  - Required response: no metric wraps, the decoded message is correct, and the saturation check on `err_cnt` holds.
- Reset mid-stream:
  - Stimulus: assert `reset` after 30 symbols.
  - Required response: `dec_valid` goes low next cycle and reappears exactly at the 15th post-reset symbol.

Source files
------------

// File: rtl/cc3_viterbi_decoder.sv
// Hard-decision 4-state register-exchange Viterbi decoder for the rate-1/2 cc3 code.
// Define CC3_ERR_COUNT_EN to add the saturating corrected-bit counter err_cnt.

module cc3_viterbi_decoder #(
  parameter int unsigned TB_DEPTH = 15,
  parameter int unsigned METRIC_W = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sym_valid,
  input  logic        sym1,
  input  logic        sym2,
  output logic        dec_valid,
  output logic        dec_bit
`ifdef CC3_ERR_COUNT_EN
  ,
  output logic [15:0] err_cnt
`endif
);

  localparam int unsigned FILL_W = $clog2(TB_DEPTH + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(TB_DEPTH);

  function automatic logic [1:0] branch_metric(input logic u, input logic a, input logic b,
                                               input logic r1, input logic r2);
    logic e1;
    logic e2;
    e1 = u ^ b;
    e2 = u ^ a ^ b;
    return {1'b0, r1 ^ e1} + {1'b0, r2 ^ e2};
  endfunction

  logic [METRIC_W-1:0] metric_q [4];
  logic [METRIC_W-1:0] metric_d [4];
  logic [TB_DEPTH-1:0] surv_q   [4];
  logic [TB_DEPTH-1:0] surv_d   [4];
  logic [1:0]          bm0      [4];
  logic [1:0]          bm1      [4];
  logic [3:0]          pick;
  logic [FILL_W-1:0]   fill_q;
  logic                acc_q;
  logic [1:0]          best;

  // State s = {u,a}; its predecessors are {a,0} and {a,1}, ties keep b=0.
  always_comb begin : acs
    logic                u;
    logic                a;
    logic [1:0]          p0;
    logic [1:0]          p1;
    logic [METRIC_W:0]   sum0;
    logic [METRIC_W:0]   sum1;
    logic [METRIC_W:0]   win;
    logic [METRIC_W-1:0] raw [4];
    logic                all_msb;
    pick    = '0;
    all_msb = 1'b1;
    for (int unsigned s = 0; s < 4; s++) begin
      u        = (s >= 2);
      a        = ((s % 2) == 1);
      p0       = {a, 1'b0};
      p1       = {a, 1'b1};
      bm0[s]   = branch_metric(u, a, 1'b0, sym1, sym2);
      bm1[s]   = branch_metric(u, a, 1'b1, sym1, sym2);
      sum0     = {1'b0, metric_q[p0]} + (METRIC_W + 1)'(bm0[s]);
      sum1     = {1'b0, metric_q[p1]} + (METRIC_W + 1)'(bm1[s]);
      pick[s]  = (sum1 < sum0);
      win      = pick[s] ? sum1 : sum0;
      raw[s]   = win[METRIC_W] ? '1 : win[METRIC_W-1:0];
      surv_d[s] = {surv_q[pick[s] ? p1 : p0][TB_DEPTH-2:0], u};
      all_msb  = all_msb & raw[s][METRIC_W-1];
    end
    // Subtracting the same half-range from every state keeps ordering intact.
    for (int unsigned s = 0; s < 4; s++) begin
      metric_d[s] = raw[s];
      if (all_msb) metric_d[s][METRIC_W-1] = 1'b0;
    end
  end

  always_comb begin : best_state
    best = 2'd0;
    for (int unsigned s = 1; s < 4; s++) begin
      if (metric_q[s] < metric_q[best]) best = 2'(s);
    end
  end

  // Outputs are taken one cycle after acceptance from the registered metrics/survivors.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned s = 0; s < 4; s++) begin
        metric_q[s] <= '0;
        surv_q[s]   <= '0;
      end
      fill_q    <= '0;
      acc_q     <= 1'b0;
      dec_valid <= 1'b0;
      dec_bit   <= 1'b0;
    end else begin
      acc_q     <= sym_valid;
      dec_valid <= acc_q && (fill_q == FILL_FULL);
      if (acc_q && (fill_q == FILL_FULL)) dec_bit <= surv_q[best][TB_DEPTH-1];
      if (sym_valid) begin
        for (int unsigned s = 0; s < 4; s++) begin
          metric_q[s] <= metric_d[s];
          surv_q[s]   <= surv_d[s];
        end
        if (fill_q != FILL_FULL) fill_q <= fill_q + FILL_W'(1);
      end
    end
  end

`ifdef CC3_ERR_COUNT_EN
  logic [1:0]  sel_bm_d [4];
  logic [1:0]  sel_bm_q [4];
  logic [16:0] err_sum;

  always_comb begin
    for (int unsigned s = 0; s < 4; s++) begin
      sel_bm_d[s] = pick[s] ? bm1[s] : bm0[s];
    end
  end

  assign err_sum = {1'b0, err_cnt} + 17'(sel_bm_q[best]);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned s = 0; s < 4; s++) sel_bm_q[s] <= '0;
      err_cnt <= '0;
    end else begin
      if (sym_valid) begin
        for (int unsigned s = 0; s < 4; s++) sel_bm_q[s] <= sel_bm_d[s];
      end
      if (acc_q) err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_cc3_viterbi_decoder.sv
// Randomised self-checking bench for cc3_viterbi_decoder against a traceback Viterbi model
// using unbounded integer metrics.

module tb_cc3_viterbi_decoder;
  localparam int unsigned TBD = 15;
  localparam int unsigned MW  = 4;

  logic clock     = 1'b0;
  logic reset     = 1'b1;
  logic sym_valid = 1'b0;
  logic sym1      = 1'b0;
  logic sym2      = 1'b0;
  logic dec_valid;
  logic dec_bit;
`ifdef CC3_ERR_COUNT_EN
  logic [15:0] err_cnt;
`endif

  cc3_viterbi_decoder #(.TB_DEPTH(TBD), .METRIC_W(MW)) dut (
    .clock     (clock),
    .reset     (reset),
    .sym_valid (sym_valid),
    .sym1      (sym1),
    .sym2      (sym2),
    .dec_valid (dec_valid),
    .dec_bit   (dec_bit)
`ifdef CC3_ERR_COUNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Behavioural model: integer path metrics, per-step decisions, traceback for the output bit.
  int  mdl_m [4];
  bit  dech [0:4095][0:3];
  int  mdl_step;
  int  mdl_fill;
  bit  p_acc, p_full, p_bit;
  int  p_bm;
  bit  e_valid, e_bit;
  int  e_err;
  bit  armed = 1'b0;
  bit  got_q [$];

  function automatic int bm_of(input int u, input int a, input int b, input int r1, input int r2);
    int e1;
    int e2;
    e1 = u ^ b;
    e2 = u ^ a ^ b;
    return int'(r1 != e1) + int'(r2 != e2);
  endfunction

  task automatic model_symbol(input int r1, input int r2);
    int nm [4];
    int bst;
    int st;
    for (int s = 0; s < 4; s++) begin
      int u;
      int a;
      int c0;
      int c1;
      u  = s / 2;
      a  = s % 2;
      c0 = mdl_m[a * 2] + bm_of(u, a, 0, r1, r2);
      c1 = mdl_m[a * 2 + 1] + bm_of(u, a, 1, r1, r2);
      dech[mdl_step][s] = (c1 < c0);
      nm[s] = (c1 < c0) ? c1 : c0;
    end
    mdl_m = nm;
    if (mdl_fill < TBD) mdl_fill++;
    bst = 0;
    for (int s = 1; s < 4; s++) if (nm[s] < nm[bst]) bst = s;
    p_bm   = bm_of(bst / 2, bst % 2, int'(dech[mdl_step][bst]), r1, r2);
    p_full = (mdl_fill == TBD);
    if (p_full) begin
      st = bst;
      for (int j = mdl_step; j > mdl_step - int'(TBD - 1); j--) st = (st % 2) * 2 + int'(dech[j][st]);
      p_bit = (st / 2) == 1;
    end
    mdl_step++;
  endtask

  // Compare against the state expected after the previous edge, then advance the model
  // with the inputs the next edge will sample.
  always @(negedge clock) begin
    if (armed) begin
      check(dec_valid === e_valid, "dec_valid", dec_valid, e_valid);
      check(dec_bit === e_bit, "dec_bit", dec_bit, e_bit);
`ifdef CC3_ERR_COUNT_EN
      check(err_cnt === 16'(e_err), "err_cnt", err_cnt, e_err);
`endif
      if (dec_valid === 1'b1) got_q.push_back(dec_bit);
    end
    if (reset) begin
      armed    = 1'b1;
      e_valid  = 1'b0;
      e_bit    = 1'b0;
      e_err    = 0;
      p_acc    = 1'b0;
      p_full   = 1'b0;
      mdl_step = 0;
      mdl_fill = 0;
      for (int s = 0; s < 4; s++) mdl_m[s] = 0;
    end else begin
      e_valid = p_acc && p_full;
      if (e_valid) e_bit = p_bit;
      if (p_acc) e_err = (e_err + p_bm > 65535) ? 65535 : e_err + p_bm;
      p_acc = sym_valid;
      if (sym_valid) model_symbol(int'(sym1), int'(sym2));
    end
  end

  // Stimulus: encoder producing the pair stream from the information bits u.
  bit q1 [$];
  bit q2 [$];
  bit msg_q [$];
  bit enc_a, enc_b;

  task automatic new_stream();
    q1.delete();
    q2.delete();
    msg_q.delete();
    enc_a = 1'b0;
    enc_b = 1'b0;
  endtask

  task automatic enc_push(input bit u, input bit f1, input bit f2);
    q1.push_back(u ^ enc_b ^ f1);
    q2.push_back(u ^ enc_a ^ enc_b ^ f2);
    msg_q.push_back(u);
    enc_b = enc_a;
    enc_a = u;
  endtask

  task automatic drive(input bit v, input bit a, input bit b);
    sym_valid = v;
    sym1      = a;
    sym2      = b;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input int unsigned cycles);
    reset     = 1'b1;
    sym_valid = 1'b1;
    repeat (cycles) begin
      sym1 = 1'($urandom);
      sym2 = 1'($urandom);
      @(posedge clock);
      #1;
    end
    reset     = 1'b0;
    sym_valid = 1'b0;
    check(dec_valid === 1'b0, "reset dec_valid", dec_valid, 0);
    check(dec_bit === 1'b0, "reset dec_bit", dec_bit, 0);
    got_q.delete();
  endtask

  task automatic send_stream(input int unsigned from, input bit gaps, input int unsigned tail);
    int unsigned c;
    int unsigned i;
    c = 0;
    i = from;
    while (i < q1.size()) begin
      if (gaps && (c % 3 == 2)) drive(1'b0, 1'($urandom), 1'($urandom));
      else begin
        drive(1'b1, q1[i], q2[i]);
        i++;
      end
      c++;
    end
    repeat (tail) drive(1'b0, 1'($urandom), 1'($urandom));
  endtask

  task automatic check_decode(input string name);
    int exp_n;
    int errs;
    exp_n = msg_q.size() - int'(TBD - 1);
    check(got_q.size() == exp_n, {name, " count"}, got_q.size(), exp_n);
    errs = 0;
    for (int i = 0; i < got_q.size() && i < msg_q.size(); i++) if (got_q[i] != msg_q[i]) errs++;
    check(errs == 0, {name, " bits"}, errs, 0);
  endtask

  initial begin
    do_reset(2);

    // No output during the first 14 accepted symbols.
    new_stream();
    repeat (14) enc_push(1'($urandom), 1'b0, 1'b0);
    send_stream(0, 1'b0, 2);
    check(got_q.size() == 0, "early dec_valid", got_q.size(), 0);

    // Impulse, noise-free; also pin the model's first-step metrics.
    do_reset(2);
    new_stream();
    enc_push(1'b1, 1'b0, 1'b0);
    repeat (22) enc_push(1'b0, 1'b0, 1'b0);
    drive(1'b1, q1[0], q2[0]);
    check(mdl_m[0] == 0 && mdl_m[1] == 1 && mdl_m[2] == 0 && mdl_m[3] == 1,
          "model metrics", mdl_m[0] * 1000 + mdl_m[1] * 100 + mdl_m[2] * 10 + mdl_m[3], 101);
    send_stream(1, 1'b0, 2);
    check_decode("impulse");
    check(got_q.size() > 0 && got_q[0] == 1'b1, "impulse first bit", got_q.size() > 0 ? got_q[0] : 0, 1);
`ifdef CC3_ERR_COUNT_EN
    check(err_cnt == 16'd0, "impulse err_cnt", err_cnt, 0);
`endif

    // Same stream with sym2 of pair 2 flipped.
    do_reset(2);
    new_stream();
    enc_push(1'b1, 1'b0, 1'b0);
    enc_push(1'b0, 1'b0, 1'b1);
    repeat (21) enc_push(1'b0, 1'b0, 1'b0);
    send_stream(0, 1'b0, 2);
    check_decode("single error");

    // Random message with sym_valid dropped every third cycle.
    do_reset(2);
    new_stream();
    repeat (64) enc_push(1'($urandom), 1'b0, 1'b0);
    repeat (20) enc_push(1'b0, 1'b0, 1'b0);
    send_stream(0, 1'b1, 3);
    check_decode("gaps");

    // Long stream with isolated flips forces repeated metric normalisation.
    do_reset(2);
    new_stream();
    for (int i = 0; i < 500; i++) begin
      bit f;
      f = (i >= 8) && (i < 480) && (i % 8 == 4);
      enc_push(i < 480 ? 1'($urandom) : 1'b0, f && (i % 16 == 4), f && (i % 16 == 12));
    end
    send_stream(0, 1'b0, 2);
    check_decode("normalisation");

    // Mid-stream reset: history discarded, refill needs 15 new symbols.
    do_reset(2);
    new_stream();
    repeat (30) enc_push(1'($urandom), 1'b0, 1'b0);
    send_stream(0, 1'b0, 0);
    do_reset(1);
    new_stream();
    repeat (20) enc_push(1'($urandom), 1'b0, 1'b0);
    send_stream(0, 1'b0, 2);
    check_decode("post-reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
